// File: rtl/fpga_main_control_block.sv
// Command decoder/sequencer between the SPI receiver and the image-memory block.
// Assembles opcode+payload frames, issues one-cycle control pulses and the image
// index, streams status/size bytes back, and keeps nav/science image counters.
module fpga_main_control_block #(
    parameter int FRAME_LEN = 9,
    parameter int CNT_W     = 12
) (
    input  logic             sysClk,
    input  logic             sysRst_n,
    input  logic [7:0]       spi_byte,
    input  logic             spi_input_valid,
    input  logic [3:0]       spi_byte_num,
    input  logic [23:0]      jpg_size_MCB,
    input  logic             jpg_size_valid_MCB,
    input  logic             done_reading_img_flag_MCB,
    input  logic             done_erasing_img_flag_MCB,
    input  logic             nav_img_added_flag_MCB,
    input  logic             science_img_added_flag_MCB,
    output logic             read_img_size_MCB,
    output logic [CNT_W-1:0] img_index_MCB,
    output logic             stop_reading_img_flag_MCB,
    output logic             reset_img_pointer_flag_MCB,
    output logic             start_reading_img_flag_MCB,
    output logic             start_erasing_img_flag_MCB,
    output logic [7:0]       byte_out_MCB,
    output logic             byte_out_valid_MCB
);

    localparam logic [3:0]       LAST_SLOT = 4'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [7:0] OP_SIZE   = 8'h01;
    localparam logic [7:0] OP_COUNTS = 8'h02;
    localparam logic [7:0] OP_READ   = 8'h03;
    localparam logic [7:0] OP_STOP   = 8'h06;
    localparam logic [7:0] OP_ERASE  = 8'h08;

    typedef enum logic [2:0] {
        IDLE, DECODE, WAIT_SIZE, START_READ, READING, WAIT_ERASE, SEND
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       opcode_q, opcode_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             frame_done_q, frame_done_d;
    logic [23:0]      resp_q, resp_d;
    logic [1:0]       resp_cnt_q, resp_cnt_d;
    logic [CNT_W-1:0] nav_q, nav_d, sci_q, sci_d;
    logic             cnt_clr;
    logic             read_size_q, read_size_d;
    logic [CNT_W-1:0] img_index_q, img_index_d;
    logic             stop_q, stop_d;
    logic             rewind_q, rewind_d;
    logic             start_read_q, start_read_d;
    logic             start_erase_q, start_erase_d;
    logic [7:0]       byte_out_q, byte_out_d;
    logic             byte_vld_q, byte_vld_d;

    // Frame capture: only the opcode and the index bytes (1 and 2) are ever
    // decoded, so only those are kept; the last slot flags a complete frame.
    always_comb begin
        opcode_d     = opcode_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        if (spi_input_valid) begin
            if (spi_byte_num == 4'd0) begin
                opcode_d = spi_byte;
                idx_d    = '0;
            end else if (spi_byte_num == 4'd1) begin
                idx_d[CNT_W-1:8] = spi_byte[CNT_W-9:0];
            end else if (spi_byte_num == 4'd2) begin
                idx_d[7:0] = spi_byte;
            end
            if (spi_byte_num == LAST_SLOT) frame_done_d = 1'b1;
        end
    end

    // Sequencer: decode completed frames, wait on the memory block, stream responses.
    always_comb begin
        state_d       = state_q;
        resp_d        = resp_q;
        resp_cnt_d    = resp_cnt_q;
        img_index_d   = img_index_q;
        read_size_d   = 1'b0;
        stop_d        = 1'b0;
        rewind_d      = 1'b0;
        start_read_d  = 1'b0;
        start_erase_d = 1'b0;
        byte_out_d    = 8'h00;
        byte_vld_d    = 1'b0;
        cnt_clr       = 1'b0;
        case (state_q)
            IDLE: if (frame_done_q) state_d = DECODE;
            DECODE: begin
                case (opcode_q)
                    OP_SIZE: begin
                        img_index_d = idx_q;
                        read_size_d = 1'b1;
                        state_d     = WAIT_SIZE;
                    end
                    OP_COUNTS: begin
                        resp_d     = {nav_q, sci_q};
                        resp_cnt_d = 2'd3;
                        state_d    = SEND;
                    end
                    OP_READ: begin
                        img_index_d = idx_q;
                        rewind_d    = 1'b1;
                        state_d     = START_READ;
                    end
                    OP_STOP: begin
                        stop_d     = 1'b1;
                        resp_d     = {8'h66, 16'h0000};
                        resp_cnt_d = 2'd1;
                        state_d    = SEND;
                    end
                    OP_ERASE: begin
                        img_index_d   = idx_q;
                        start_erase_d = 1'b1;
                        state_d       = WAIT_ERASE;
                    end
                    default: begin
                        resp_d     = {8'hEE, 16'h0000};
                        resp_cnt_d = 2'd1;
                        state_d    = SEND;
                    end
                endcase
            end
            WAIT_SIZE: begin
                if (jpg_size_valid_MCB) begin
                    resp_d     = jpg_size_MCB;
                    resp_cnt_d = 2'd3;
                    state_d    = SEND;
                end
            end
            START_READ: begin
                start_read_d = 1'b1;
                state_d      = READING;
            end
            READING: begin
                // An abort takes precedence over a read finishing in the same cycle.
                if (frame_done_q && opcode_q == OP_STOP) begin
                    stop_d     = 1'b1;
                    resp_d     = {8'h66, 16'h0000};
                    resp_cnt_d = 2'd1;
                    state_d    = SEND;
                end else if (done_reading_img_flag_MCB) begin
                    resp_d     = {8'h55, 16'h0000};
                    resp_cnt_d = 2'd1;
                    state_d    = SEND;
                end
            end
            WAIT_ERASE: begin
                if (done_erasing_img_flag_MCB) begin
                    cnt_clr    = 1'b1;
                    resp_d     = {8'hAA, 16'h0000};
                    resp_cnt_d = 2'd1;
                    state_d    = SEND;
                end
            end
            SEND: begin
                byte_out_d = resp_q[23:16];
                byte_vld_d = 1'b1;
                resp_d     = {resp_q[15:0], 8'h00};
                resp_cnt_d = resp_cnt_q - 2'd1;
                if (resp_cnt_q <= 2'd1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Image counters: saturating increments, erase clear overrides any increment.
    always_comb begin
        nav_d = nav_q;
        sci_d = sci_q;
        if (cnt_clr) begin
            nav_d = '0;
            sci_d = '0;
        end else begin
            if (nav_img_added_flag_MCB && nav_q != CNT_MAX) nav_d = nav_q + 1'b1;
            if (science_img_added_flag_MCB && sci_q != CNT_MAX) sci_d = sci_q + 1'b1;
        end
    end

    // State, capture, counter and output registers.
    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state_q       <= IDLE;
            opcode_q      <= 8'h00;
            idx_q         <= '0;
            frame_done_q  <= 1'b0;
            resp_q        <= 24'h0;
            resp_cnt_q    <= 2'd0;
            nav_q         <= '0;
            sci_q         <= '0;
            read_size_q   <= 1'b0;
            img_index_q   <= '0;
            stop_q        <= 1'b0;
            rewind_q      <= 1'b0;
            start_read_q  <= 1'b0;
            start_erase_q <= 1'b0;
            byte_out_q    <= 8'h00;
            byte_vld_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            opcode_q      <= opcode_d;
            idx_q         <= idx_d;
            frame_done_q  <= frame_done_d;
            resp_q        <= resp_d;
            resp_cnt_q    <= resp_cnt_d;
            nav_q         <= nav_d;
            sci_q         <= sci_d;
            read_size_q   <= read_size_d;
            img_index_q   <= img_index_d;
            stop_q        <= stop_d;
            rewind_q      <= rewind_d;
            start_read_q  <= start_read_d;
            start_erase_q <= start_erase_d;
            byte_out_q    <= byte_out_d;
            byte_vld_q    <= byte_vld_d;
        end
    end

    assign read_img_size_MCB          = read_size_q;
    assign img_index_MCB              = img_index_q;
    assign stop_reading_img_flag_MCB  = stop_q;
    assign reset_img_pointer_flag_MCB = rewind_q;
    assign start_reading_img_flag_MCB = start_read_q;
    assign start_erasing_img_flag_MCB = start_erase_q;
    assign byte_out_MCB               = byte_out_q;
    assign byte_out_valid_MCB         = byte_vld_q;

endmodule

// File: tb/tb_fpga_main_control_block.sv
// Directed testbench for fpga_main_control_block.
module tb_fpga_main_control_block;

    logic        sysClk = 1'b0;
    logic        sysRst_n = 1'b1;
    logic [7:0]  spi_byte = 8'h00;
    logic        spi_input_valid = 1'b0;
    logic [3:0]  spi_byte_num = 4'd0;
    logic [23:0] jpg_size_MCB = 24'h0;
    logic        jpg_size_valid_MCB = 1'b0;
    logic        done_reading_img_flag_MCB = 1'b0;
    logic        done_erasing_img_flag_MCB = 1'b0;
    logic        nav_img_added_flag_MCB = 1'b0;
    logic        science_img_added_flag_MCB = 1'b0;
    logic        read_img_size_MCB;
    logic [11:0] img_index_MCB;
    logic        stop_reading_img_flag_MCB;
    logic        reset_img_pointer_flag_MCB;
    logic        start_reading_img_flag_MCB;
    logic        start_erasing_img_flag_MCB;
    logic [7:0]  byte_out_MCB;
    logic        byte_out_valid_MCB;

    fpga_main_control_block dut (
        .sysClk                     (sysClk),
        .sysRst_n                   (sysRst_n),
        .spi_byte                   (spi_byte),
        .spi_input_valid            (spi_input_valid),
        .spi_byte_num               (spi_byte_num),
        .jpg_size_MCB               (jpg_size_MCB),
        .jpg_size_valid_MCB         (jpg_size_valid_MCB),
        .done_reading_img_flag_MCB  (done_reading_img_flag_MCB),
        .done_erasing_img_flag_MCB  (done_erasing_img_flag_MCB),
        .nav_img_added_flag_MCB     (nav_img_added_flag_MCB),
        .science_img_added_flag_MCB (science_img_added_flag_MCB),
        .read_img_size_MCB          (read_img_size_MCB),
        .img_index_MCB              (img_index_MCB),
        .stop_reading_img_flag_MCB  (stop_reading_img_flag_MCB),
        .reset_img_pointer_flag_MCB (reset_img_pointer_flag_MCB),
        .start_reading_img_flag_MCB (start_reading_img_flag_MCB),
        .start_erasing_img_flag_MCB (start_erasing_img_flag_MCB),
        .byte_out_MCB               (byte_out_MCB),
        .byte_out_valid_MCB         (byte_out_valid_MCB)
    );

    always #5 sysClk = ~sysClk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_rs, n_stop, n_rp, n_sr, n_se;
    int rp_cyc, sr_cyc;
    logic [7:0] bq[$];
    int bc[$];

    always @(posedge sysClk) cyc <= cyc + 1;

    // Record pulses and response bytes, sampled on the falling edge.
    always @(negedge sysClk) begin
        if (read_img_size_MCB) n_rs++;
        if (stop_reading_img_flag_MCB) n_stop++;
        if (reset_img_pointer_flag_MCB) begin n_rp++; rp_cyc = cyc; end
        if (start_reading_img_flag_MCB) begin n_sr++; sr_cyc = cyc; end
        if (start_erasing_img_flag_MCB) n_se++;
        if (byte_out_valid_MCB) begin
            bq.push_back(byte_out_MCB);
            bc.push_back(cyc);
        end
    end

    task clear_mon();
        n_rs = 0; n_stop = 0; n_rp = 0; n_sr = 0; n_se = 0;
        rp_cyc = 0; sr_cyc = 0;
        bq.delete();
        bc.delete();
    endtask

    task send_frame(input logic [7:0] op, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] fb [9];
        for (int i = 0; i < 9; i++) fb[i] = 8'h00;
        fb[0] = op; fb[1] = b1; fb[2] = b2;
        for (int i = 0; i < 9; i++) begin
            @(posedge sysClk); #1;
            spi_input_valid = 1'b1;
            spi_byte        = fb[i];
            spi_byte_num    = 4'(i);
        end
        @(posedge sysClk); #1;
        spi_input_valid = 1'b0;
        spi_byte        = 8'h00;
        spi_byte_num    = 4'd0;
    endtask

    task test_reset();
        clear_mon();
        #2 sysRst_n = 1'b0;
        #2;
        checks++;
        if ({read_img_size_MCB, img_index_MCB, stop_reading_img_flag_MCB, reset_img_pointer_flag_MCB,
             start_reading_img_flag_MCB, start_erasing_img_flag_MCB, byte_out_MCB, byte_out_valid_MCB} !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs: index=%h byte=%h vld=%b, required all zero",
                     img_index_MCB, byte_out_MCB, byte_out_valid_MCB);
        end
        repeat (3) @(posedge sysClk);
        #1 sysRst_n = 1'b1;
        repeat (2) @(posedge sysClk);
        #1;
    endtask

    task test_size();
        clear_mon();
        send_frame(8'h01, 8'h00, 8'h00);
        repeat (6) @(posedge sysClk);
        #1;
        checks++;
        if (n_rs !== 1) begin errors++; $display("FAIL size_pulse: got %0d pulses, required 1", n_rs); end
        checks++;
        if (img_index_MCB !== 12'h000) begin errors++; $display("FAIL size_index: got %h, required 000", img_index_MCB); end
        jpg_size_MCB = 24'h123456;
        jpg_size_valid_MCB = 1'b1;
        @(posedge sysClk); #1;
        jpg_size_valid_MCB = 1'b0;
        jpg_size_MCB = 24'h0;
        repeat (8) @(posedge sysClk);
        #1;
        checks++;
        if (bq.size() !== 3) begin
            errors++; $display("FAIL size_count: got %0d bytes, required 3", bq.size());
        end else begin
            checks++;
            if ({bq[0], bq[1], bq[2]} !== 24'h123456) begin
                errors++; $display("FAIL size_bytes: got %h %h %h, required 12 34 56", bq[0], bq[1], bq[2]);
            end
            checks++;
            if (bc[1] != bc[0] + 1 || bc[2] != bc[1] + 1) begin
                errors++; $display("FAIL size_consecutive: cycles %0d %0d %0d, required consecutive", bc[0], bc[1], bc[2]);
            end
        end
    endtask

    task test_read();
        clear_mon();
        send_frame(8'h03, 8'h0A, 8'h1B);
        repeat (6) @(posedge sysClk);
        #1;
        checks++;
        if (img_index_MCB !== 12'hA1B) begin errors++; $display("FAIL read_index: got %h, required a1b", img_index_MCB); end
        checks++;
        if (n_rp !== 1 || n_sr !== 1) begin
            errors++; $display("FAIL read_pulses: rewind=%0d start=%0d, required 1 and 1", n_rp, n_sr);
        end
        checks++;
        if (sr_cyc != rp_cyc + 1) begin
            errors++; $display("FAIL read_order: rewind cyc %0d start cyc %0d, required start one later", rp_cyc, sr_cyc);
        end
        done_reading_img_flag_MCB = 1'b1;
        @(posedge sysClk); #1;
        done_reading_img_flag_MCB = 1'b0;
        repeat (6) @(posedge sysClk);
        #1;
        checks++;
        if (bq.size() !== 1 || bq[0] !== 8'h55) begin
            errors++; $display("FAIL read_done_byte: got %0d bytes first %h, required one byte 55", bq.size(), bq[0]);
        end
    endtask

    task test_stop();
        clear_mon();
        send_frame(8'h03, 8'h0A, 8'h1B);
        repeat (6) @(posedge sysClk);
        send_frame(8'h01, 8'h00, 8'h05);
        repeat (6) @(posedge sysClk);
        #1;
        checks++;
        if (n_rs !== 0) begin errors++; $display("FAIL stop_drop_size: got %0d size pulses, required 0", n_rs); end
        checks++;
        if (img_index_MCB !== 12'hA1B) begin errors++; $display("FAIL stop_index_hold: got %h, required a1b", img_index_MCB); end
        send_frame(8'h06, 8'h00, 8'h00);
        repeat (8) @(posedge sysClk);
        #1;
        checks++;
        if (n_stop !== 1) begin errors++; $display("FAIL stop_pulse: got %0d, required 1", n_stop); end
        checks++;
        if (bq.size() !== 1 || bq[0] !== 8'h66) begin
            errors++; $display("FAIL stop_byte: got %0d bytes first %h, required one byte 66", bq.size(), bq[0]);
        end
        done_reading_img_flag_MCB = 1'b1;
        @(posedge sysClk); #1;
        done_reading_img_flag_MCB = 1'b0;
        repeat (6) @(posedge sysClk);
        #1;
        checks++;
        if (bq.size() !== 1) begin errors++; $display("FAIL stop_idle: got %0d bytes, required 1", bq.size()); end
    endtask

    task test_counts();
        clear_mon();
        @(posedge sysClk); #1;
        nav_img_added_flag_MCB = 1'b1;
        @(posedge sysClk); #1;
        science_img_added_flag_MCB = 1'b1;
        @(posedge sysClk); #1;
        science_img_added_flag_MCB = 1'b0;
        @(posedge sysClk); #1;
        nav_img_added_flag_MCB = 1'b0;
        science_img_added_flag_MCB = 1'b1;
        @(posedge sysClk); #1;
        science_img_added_flag_MCB = 1'b0;
        send_frame(8'h02, 8'h00, 8'h00);
        repeat (8) @(posedge sysClk);
        #1;
        checks++;
        if (bq.size() !== 3 || {bq[0], bq[1], bq[2]} !== 24'h003002) begin
            errors++; $display("FAIL counts_bytes: got %0d bytes %h %h %h, required 00 30 02", bq.size(), bq[0], bq[1], bq[2]);
        end
        clear_mon();
        send_frame(8'h08, 8'h00, 8'h00);
        repeat (6) @(posedge sysClk);
        #1;
        checks++;
        if (n_se !== 1 || img_index_MCB !== 12'h000) begin
            errors++; $display("FAIL erase_start: pulses=%0d index=%h, required 1 and 000", n_se, img_index_MCB);
        end
        done_erasing_img_flag_MCB = 1'b1;
        nav_img_added_flag_MCB = 1'b1;
        @(posedge sysClk); #1;
        done_erasing_img_flag_MCB = 1'b0;
        nav_img_added_flag_MCB = 1'b0;
        repeat (6) @(posedge sysClk);
        #1;
        checks++;
        if (bq.size() !== 1 || bq[0] !== 8'hAA) begin
            errors++; $display("FAIL erase_byte: got %0d bytes first %h, required one byte aa", bq.size(), bq[0]);
        end
        clear_mon();
        send_frame(8'h02, 8'h00, 8'h00);
        repeat (8) @(posedge sysClk);
        #1;
        checks++;
        if (bq.size() !== 3 || {bq[0], bq[1], bq[2]} !== 24'h000000) begin
            errors++; $display("FAIL erase_cleared: got %0d bytes %h %h %h, required 00 00 00", bq.size(), bq[0], bq[1], bq[2]);
        end
    endtask

    task test_saturate();
        clear_mon();
        @(posedge sysClk); #1;
        nav_img_added_flag_MCB = 1'b1;
        science_img_added_flag_MCB = 1'b1;
        @(posedge sysClk); #1;
        science_img_added_flag_MCB = 1'b0;
        repeat (4100) @(posedge sysClk);
        #1 nav_img_added_flag_MCB = 1'b0;
        send_frame(8'h02, 8'h00, 8'h00);
        repeat (8) @(posedge sysClk);
        #1;
        checks++;
        if (bq.size() !== 3 || {bq[0], bq[1], bq[2]} !== 24'hFFF001) begin
            errors++; $display("FAIL counts_saturate: got %0d bytes %h %h %h, required ff f0 01", bq.size(), bq[0], bq[1], bq[2]);
        end
    endtask

    task test_bad_opcode();
        clear_mon();
        send_frame(8'h7F, 8'h00, 8'h00);
        repeat (10) @(posedge sysClk);
        #1;
        checks++;
        if (bq.size() !== 1 || bq[0] !== 8'hEE) begin
            errors++; $display("FAIL bad_opcode: got %0d bytes first %h, required one byte ee", bq.size(), bq[0]);
        end
    endtask

    task test_ignored_slot();
        clear_mon();
        for (int i = 0; i < 10; i++) begin
            if (i != 8) begin
                @(posedge sysClk); #1;
                spi_input_valid = 1'b1;
                spi_byte        = (i == 0) ? 8'h03 : 8'h11;
                spi_byte_num    = 4'(i);
            end
        end
        @(posedge sysClk); #1;
        spi_input_valid = 1'b0;
        spi_byte_num    = 4'd0;
        repeat (10) @(posedge sysClk);
        #1;
        checks++;
        if (n_rp !== 0 || bq.size() !== 0) begin
            errors++; $display("FAIL slot9_ignored: rewind=%0d bytes=%0d, required 0 and 0", n_rp, bq.size());
        end
    endtask

    task test_reset_mid_erase();
        clear_mon();
        send_frame(8'h08, 8'h0A, 8'h1B);
        repeat (6) @(posedge sysClk);
        #1;
        checks++;
        if (n_se !== 1 || img_index_MCB !== 12'hA1B) begin
            errors++; $display("FAIL erase_pre: pulses=%0d index=%h, required 1 and a1b", n_se, img_index_MCB);
        end
        @(posedge sysClk); #3;
        sysRst_n = 1'b0;
        #1;
        checks++;
        if ({read_img_size_MCB, img_index_MCB, stop_reading_img_flag_MCB, reset_img_pointer_flag_MCB,
             start_reading_img_flag_MCB, start_erasing_img_flag_MCB, byte_out_MCB, byte_out_valid_MCB} !== 26'd0) begin
            errors++; $display("FAIL async_reset: index=%h, required all outputs zero", img_index_MCB);
        end
        repeat (2) @(posedge sysClk);
        #1 sysRst_n = 1'b1;
        done_erasing_img_flag_MCB = 1'b1;
        @(posedge sysClk); #1;
        done_erasing_img_flag_MCB = 1'b0;
        repeat (6) @(posedge sysClk);
        #1;
        checks++;
        if (bq.size() !== 0) begin errors++; $display("FAIL reset_idle: got %0d bytes, required 0", bq.size()); end
        send_frame(8'h7F, 8'h00, 8'h00);
        repeat (10) @(posedge sysClk);
        #1;
        checks++;
        if (bq.size() !== 1 || bq[0] !== 8'hEE) begin
            errors++; $display("FAIL reset_next_frame: got %0d bytes first %h, required one byte ee", bq.size(), bq[0]);
        end
    endtask

    initial begin
        test_reset();
        test_size();
        test_read();
        test_stop();
        test_counts();
        test_saturate();
        test_bad_opcode();
        test_ignored_slot();
        test_reset_mid_erase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
